// File: rtl/lottery_input_conditioner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | lottery_input_conditioner: sync, debounce and edge-detect DE2 keys/switches |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module lottery_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_insert_n,
  input  logic       key_finish_n,
  input  logic [3:0] sw_num,
  output logic [3:0] num_out,
  output logic       insert_pulse,
  output logic       finish_pulse,
  output logic       invalid_flag
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] key_raw;
  logic [1:0] key_s1;
  logic [1:0] key_s2;
  logic [1:0] press;
  logic [3:0] sw_s1;
  logic [3:0] sw_s2;
  logic       finish_pending;
  logic       ins_press;
  logic       fin_press;
  logic       digit_ok;
  logic       fin_want;

  assign key_raw = {key_finish_n, key_insert_n};

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      sw_s1  <= 4'd0;
      sw_s2  <= 4'd0;
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      sw_s1  <= sw_num;
      sw_s2  <= sw_s1;
    end
  end

  // Bit 0 is INSERT, bit 1 is FINISH; a press is the stable 1->0 flip itself.
  for (genvar i = 0; i < 2; i++) begin : g_key
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign flip     = (key_s2[i] != stable) && (cnt == CNT_LAST);
    assign press[i] = flip && !key_s2[i];

    always_ff @(posedge clk) begin
      if (reset) begin
        stable <= 1'b1;
        cnt    <= '0;
      end else if (key_s2[i] == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= key_s2[i];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign ins_press = press[0];
  assign fin_press = press[1];
  assign digit_ok  = (sw_s2 <= 4'd9);
  // A finish colliding with an insert press is held one cycle so strobes never overlap.
  assign fin_want  = finish_pending || fin_press;

  always_ff @(posedge clk) begin
    if (reset) begin
      num_out        <= 4'd0;
      insert_pulse   <= 1'b0;
      finish_pulse   <= 1'b0;
      invalid_flag   <= 1'b0;
      finish_pending <= 1'b0;
    end else begin
      insert_pulse   <= ins_press && digit_ok;
      finish_pulse   <= fin_want && !ins_press;
      finish_pending <= fin_want && ins_press;
      if (ins_press) begin
        if (digit_ok) begin
          num_out      <= sw_s2;
          invalid_flag <= 1'b0;
        end else begin
          invalid_flag <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
